// File: rtl/gcd_pkg.sv
// Shared types and defaults for the streaming GCD engine.
package gcd_pkg;

  localparam int GCD_WIDTH_DEF = 8;
  localparam int GCD_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } gcd_state_e;

endpackage

// File: rtl/gcd_stream_if.sv
// Operand/result handshake bundle for gcd_stream; y_err exists only with GCD_ZERO_ERR_EN.
interface gcd_stream_if
  import gcd_pkg::*;
#(
  parameter int WIDTH     = GCD_WIDTH_DEF,
  parameter int OUT_DEPTH = GCD_DEPTH_DEF
);

  logic [WIDTH-1:0]                 a_data;
  logic                             a_en;
  logic                             a_rdy;
  logic [WIDTH-1:0]                 b_data;
  logic                             b_en;
  logic                             b_rdy;
  logic [WIDTH-1:0]                 y_data;
  logic                             y_en;
  logic                             y_rdy;
  logic                             busy_o;
  logic [$clog2(OUT_DEPTH+1)-1:0]   y_count;
`ifdef GCD_ZERO_ERR_EN
  logic                             y_err;

  modport slave  (input  a_data, a_en, b_data, b_en, y_en,
                  output a_rdy, b_rdy, y_data, y_rdy, busy_o, y_count, y_err);
  modport master (output a_data, a_en, b_data, b_en, y_en,
                  input  a_rdy, b_rdy, y_data, y_rdy, busy_o, y_count, y_err);
`else
  modport slave  (input  a_data, a_en, b_data, b_en, y_en,
                  output a_rdy, b_rdy, y_data, y_rdy, busy_o, y_count);
  modport master (output a_data, a_en, b_data, b_en, y_en,
                  input  a_rdy, b_rdy, y_data, y_rdy, busy_o, y_count);
`endif

endinterface

// File: rtl/gcd_fifo.sv
// First-word-fall-through FIFO: head visible combinationally (0 when empty), push/pop take effect at the edge.
// Push while full and pop while empty are ignored; full is a decode of the registered count only.
module gcd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_data,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_data,
  output logic                         o_full,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;
  logic             w_empty;

  assign w_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;
  assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !w_empty;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Power-of-two depth: pointers wrap by natural overflow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/gcd_stream.sv
// Buffered Euclid GCD: launches only with a result slot free; pop edge to y_rdy = 1 + C + 1 edges.
// Inputs backpressure via a_rdy/b_rdy (FIFO full); GCD_ZERO_ERR_EN adds y_err flagging gcd(0,0).
module gcd_stream
  import gcd_pkg::*;
#(
  parameter int WIDTH     = GCD_WIDTH_DEF,
  parameter int IN_DEPTH  = GCD_DEPTH_DEF,
  parameter int OUT_DEPTH = GCD_DEPTH_DEF
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  gcd_stream_if.slave   bus
);

`ifdef GCD_ZERO_ERR_EN
  localparam int YW = WIDTH + 1;
`else
  localparam int YW = WIDTH;
`endif
  localparam int ICW = $clog2(IN_DEPTH+1);
  localparam int OCW = $clog2(OUT_DEPTH+1);

  logic [WIDTH-1:0] w_a_dat, w_b_dat;
  logic             w_a_full, w_b_full, w_y_full;
  logic [ICW-1:0]   w_a_cnt, w_b_cnt;
  logic [OCW-1:0]   w_y_cnt;
  logic [YW-1:0]    w_y_in, w_y_dat;
  logic             w_launch, w_y_push;

  gcd_state_e       r_state;
  logic [WIDTH-1:0] r_a, r_b, r_res;
  logic             r_busy;
`ifdef GCD_ZERO_ERR_EN
  logic             r_err;
  assign w_y_in     = {r_err, r_res};
  assign bus.y_err  = w_y_dat[WIDTH];
`else
  assign w_y_in     = r_res;
`endif

  gcd_fifo #(.WIDTH(WIDTH), .DEPTH(IN_DEPTH)) u_a_fifo (
    .clk_i  (clk_i),    .rst_ni (rst_ni),
    .i_push (bus.a_en), .i_data (bus.a_data), .i_pop (w_launch),
    .o_data (w_a_dat),  .o_full (w_a_full),   .o_count (w_a_cnt)
  );

  gcd_fifo #(.WIDTH(WIDTH), .DEPTH(IN_DEPTH)) u_b_fifo (
    .clk_i  (clk_i),    .rst_ni (rst_ni),
    .i_push (bus.b_en), .i_data (bus.b_data), .i_pop (w_launch),
    .o_data (w_b_dat),  .o_full (w_b_full),   .o_count (w_b_cnt)
  );

  gcd_fifo #(.WIDTH(YW), .DEPTH(OUT_DEPTH)) u_y_fifo (
    .clk_i  (clk_i),    .rst_ni (rst_ni),
    .i_push (w_y_push), .i_data (w_y_in),  .i_pop (bus.y_en),
    .o_data (w_y_dat),  .o_full (w_y_full), .o_count (w_y_cnt)
  );

  // Result FIFO not full is the slot reservation: only one op is ever in flight.
  assign w_launch = (r_state == IDLE) && (w_a_cnt != '0) && (w_b_cnt != '0) && !w_y_full;
  assign w_y_push = (r_state == DONE);

  assign bus.a_rdy   = !w_a_full;
  assign bus.b_rdy   = !w_b_full;
  assign bus.y_data  = w_y_dat[WIDTH-1:0];
  assign bus.y_rdy   = (w_y_cnt != '0);
  assign bus.y_count = w_y_cnt;
  assign bus.busy_o  = r_busy;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_busy  <= 1'b0;
`ifdef GCD_ZERO_ERR_EN
      r_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_launch) begin
            r_a     <= w_a_dat;
            r_b     <= w_b_dat;
            r_busy  <= 1'b1;
            r_state <= CALC;
`ifdef GCD_ZERO_ERR_EN
            r_err   <= (w_a_dat == '0) && (w_b_dat == '0);
`endif
          end
        end
        CALC: begin
          if (r_b == '0) begin
            r_res   <= r_a;
            r_state <= DONE;
          end else if (r_a < r_b) begin
            r_a <= r_b;
            r_b <= r_a;
          end else begin
            r_a <= r_a - r_b;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_stream.sv
// Directed bench for gcd_stream: latency, zero cases, ordering, full-drop, backpressure, reset.
module tb_gcd_stream;
  import gcd_pkg::*;

  localparam int W = 8;

  logic clk_i = 1'b0;
  logic rst_ni;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk_i = ~clk_i;

  gcd_stream_if #(.WIDTH(W), .OUT_DEPTH(4)) bus ();

  gcd_stream #(.WIDTH(W), .IN_DEPTH(4), .OUT_DEPTH(4)) u_dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_pair(input string tag, input int a, input int b);
    int k = 0;
    while (!(bus.a_rdy && bus.b_rdy) && k < 300) begin
      tick();
      k++;
    end
    if (!(bus.a_rdy && bus.b_rdy)) check({tag, "_rdy_timeout"}, 0, 1);
    bus.a_data = W'(a);
    bus.b_data = W'(b);
    bus.a_en   = 1'b1;
    bus.b_en   = 1'b1;
    tick();
    bus.a_en   = 1'b0;
    bus.b_en   = 1'b0;
  endtask

  task automatic pop_check(input string tag, input int exp);
    check(tag, int'(bus.y_data), exp);
    bus.y_en = 1'b1;
    tick();
    bus.y_en = 1'b0;
  endtask

  task automatic wait_count(input string tag, input int target);
    int k = 0;
    while (int'(bus.y_count) != target && k < 3000) begin
      tick();
      k++;
    end
    check(tag, int'(bus.y_count), target);
  endtask

  // Edges counted from the push edge; launch happens on the following edge.
  task automatic run_op(input string tag, input int a, input int b,
                        input int exp_y, input int exp_lat, input int exp_err);
    int n = 0;
    push_pair(tag, a, b);
    while (!bus.y_rdy && n < 500) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, n, exp_lat);
`ifdef GCD_ZERO_ERR_EN
    check({tag, "_err"}, int'(bus.y_err), exp_err);
`else
    if (exp_err > 1) check({tag, "_err_arg"}, exp_err, 0);
`endif
    pop_check({tag, "_y"}, exp_y);
    check({tag, "_empty"}, int'(bus.y_rdy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int av[4] = '{48, 7, 100, 255};
    int bv[4] = '{18, 7, 75, 17};
    int yv[4] = '{6, 7, 25, 17};
    int bpa[6] = '{6, 9, 10, 14, 22, 26};
    int bpb[6] = '{4, 6, 5, 21, 33, 39};

    rst_ni   = 1'b0;
    bus.a_en = 1'b0; bus.b_en = 1'b0; bus.y_en = 1'b0;
    bus.a_data = '0; bus.b_data = '0;
    tick(); tick();
    check("rst_a_rdy", int'(bus.a_rdy), 1);
    check("rst_b_rdy", int'(bus.b_rdy), 1);
    check("rst_y_rdy", int'(bus.y_rdy), 0);
    check("rst_y_data", int'(bus.y_data), 0);
    check("rst_busy", int'(bus.busy_o), 0);
    check("rst_y_count", int'(bus.y_count), 0);
`ifdef GCD_ZERO_ERR_EN
    check("rst_y_err", int'(bus.y_err), 0);
`endif
    rst_ni = 1'b1;
    tick();

    // (12,8): 6 CALC steps; (0,9): swap then detect.
    run_op("gcd12_8", 12, 8, 4, 8, 0);
    run_op("gcd5_0",  5,  0, 5, 3, 0);
    run_op("gcd0_9",  0,  9, 9, 4, 0);
    run_op("gcd0_0",  0,  0, 0, 3, 1);

    for (int i = 0; i < 4; i++) begin
      bus.a_data = W'(av[i]); bus.a_en = 1'b1;
      tick();
    end
    bus.a_en = 1'b0;
    check("ord_a_full", int'(bus.a_rdy), 0);
    bus.a_data = 8'd99; bus.a_en = 1'b1;
    tick();
    bus.a_en = 1'b0;
    check("ord_a_still_full", int'(bus.a_rdy), 0);
    for (int i = 0; i < 4; i++) begin
      bus.b_data = W'(bv[i]); bus.b_en = 1'b1;
      tick();
    end
    bus.b_en = 1'b0;
    wait_count("ord_cnt", 4);
    for (int i = 0; i < 4; i++) pop_check($sformatf("ord_y%0d", i), yv[i]);
    check("ord_drained", int'(bus.y_rdy), 0);
    // A lone B must not launch if the 5th A push was really dropped.
    bus.b_data = 8'd33; bus.b_en = 1'b1;
    tick();
    bus.b_en = 1'b0;
    repeat (20) tick();
    check("ord_drop_no_launch", int'(bus.y_count), 0);
    bus.a_data = 8'd22; bus.a_en = 1'b1;
    tick();
    bus.a_en = 1'b0;
    wait_count("ord_late_cnt", 1);
    pop_check("ord_late_y", 11);

    for (int i = 0; i < 6; i++) push_pair($sformatf("bp_push%0d", i), bpa[i], bpb[i]);
    wait_count("bp_sat", 4);
    repeat (30) tick();
    check("bp_hold_cnt", int'(bus.y_count), 4);
    check("bp_idle", int'(bus.busy_o), 0);
    pop_check("bp_y0", 2);
    wait_count("bp_refill", 4);
    repeat (30) tick();
    check("bp_one_launch_idle", int'(bus.busy_o), 0);
    pop_check("bp_y1", 3);
    pop_check("bp_y2", 5);
    pop_check("bp_y3", 7);
    pop_check("bp_y4", 11);
    wait_count("bp_last_cnt", 1);
    pop_check("bp_y5", 13);
    check("bp_drained", int'(bus.y_rdy), 0);

    push_pair("cc_p0", 6, 4);
    push_pair("cc_p1", 9, 6);
    push_pair("cc_p2", 10, 5);
    wait_count("cc_fill", 3);
    push_pair("cc_p3", 5, 0);
    tick();
    tick();
    check("cc_pre_cnt", int'(bus.y_count), 3);
    check("cc_pre_busy", int'(bus.busy_o), 1);
    bus.y_en = 1'b1;
    tick();
    bus.y_en = 1'b0;
    check("cc_post_cnt", int'(bus.y_count), 3);
    pop_check("cc_y0", 3);
    pop_check("cc_y1", 5);
    pop_check("cc_y2", 5);
    check("cc_drained", int'(bus.y_rdy), 0);

    push_pair("rs_p0", 200, 3);
    push_pair("rs_p1", 9, 3);
    repeat (5) tick();
    check("rs_busy_pre", int'(bus.busy_o), 1);
    rst_ni = 1'b0;
    tick();
    check("rs_busy", int'(bus.busy_o), 0);
    check("rs_y_rdy", int'(bus.y_rdy), 0);
    check("rs_a_rdy", int'(bus.a_rdy), 1);
    check("rs_b_rdy", int'(bus.b_rdy), 1);
    check("rs_y_count", int'(bus.y_count), 0);
    check("rs_y_data", int'(bus.y_data), 0);
    rst_ni = 1'b1;
    repeat (20) tick();
    check("rs_discard_cnt", int'(bus.y_count), 0);
    check("rs_discard_busy", int'(bus.busy_o), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
